// File: rtl/mux_nch_scan.sv
// Registered N-channel x W-bit multiplexer with manual select and round-robin auto-scan.
// Outputs carry valid, channel tag and a one-cycle wrap pulse.
module mux_nch_scan #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel,
    input  logic                 enable,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_ch,
    output logic                 wrap
);

    localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  ptr_q, ptr_d, cur_ptr;
    logic [CNTW-1:0]  cnt_q, cnt_d, cur_cnt;
    logic [SELW-1:0]  src;
    logic             src_ok;
    logic [WIDTH-1:0] mux;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic [SELW-1:0]  ch_d;
    logic             wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        if (!enable) begin
            state_d = IDLE;
        end else if (mode) begin
            state_d = SCAN;
        end else begin
            state_d = MANUAL;
        end
    end

    // The scan position only carries over if the previous edge was also a scan edge;
    // any other entry into SCAN starts fresh at channel 0, count 0.
    always_comb begin
        cur_ptr = (state_q == SCAN) ? ptr_q : '0;
        cur_cnt = (state_q == SCAN) ? cnt_q : '0;
    end

    always_comb begin
        src    = (state_d == SCAN) ? cur_ptr : sel;
        mux    = '0;
        src_ok = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (src == SELW'(i)) begin
                mux    = din[i*WIDTH +: WIDTH];
                src_ok = 1'b1;
            end
        end
    end

    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        ch_d    = '0;
        wrap_d  = 1'b0;
        ptr_d   = '0;
        cnt_d   = '0;
        case (state_d)
            MANUAL: begin
                if (src_ok) begin
                    out_d   = mux;
                    valid_d = 1'b1;
                    ch_d    = sel;
                end
            end
            SCAN: begin
                out_d   = mux;
                valid_d = 1'b1;
                ch_d    = cur_ptr;
                wrap_d  = (state_q == SCAN) && (cur_ptr == '0) && (cur_cnt == '0);
                if (cur_cnt == CNTW'(DWELL - 1)) begin
                    cnt_d = '0;
                    ptr_d = (cur_ptr == SELW'(NCH - 1)) ? '0 : cur_ptr + 1'b1;
                end else begin
                    cnt_d = cur_cnt + 1'b1;
                    ptr_d = cur_ptr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            wrap      <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            out       <= out_d;
            out_valid <= valid_d;
            out_ch    <= ch_d;
            wrap      <= wrap_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Scoreboard bench for mux_nch_scan: a 4-channel DWELL=2 instance and a 3-channel DWELL=1 instance.
module tb_mux_nch_scan;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] din4;
    logic [1:0]  sel4;
    logic        en4, md4;
    logic [3:0]  o4;
    logic        v4, w4;
    logic [1:0]  ch4;

    logic [11:0] din3;
    logic [1:0]  sel3;
    logic        en3, md3;
    logic [3:0]  o3;
    logic        v3, w3;
    logic [1:0]  ch3;

    always #5 clk = ~clk;

    mux_nch_scan #(.WIDTH(4), .NCH(4), .SELW(2), .DWELL(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .enable(en4), .mode(md4),
        .out(o4), .out_valid(v4), .out_ch(ch4), .wrap(w4)
    );

    mux_nch_scan #(.WIDTH(4), .NCH(3), .SELW(2), .DWELL(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .enable(en3), .mode(md3),
        .out(o3), .out_valid(v3), .out_ch(ch3), .wrap(w3)
    );

    typedef struct packed {
        logic [3:0] out;
        logic       valid;
        logic [1:0] ch;
        logic       wrap;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int   n4 = 0, n3 = 0;
    bit   sc4 = 1'b0, sc3 = 1'b0;
    int   vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the edge index n of the current scan run.
    function automatic exp_t predict(input logic en, input logic md, input logic [1:0] s,
                                     input logic [15:0] d, input int nch, input int dwell,
                                     input int n);
        exp_t e;
        int   c;
        e = '0;
        if (en && !md) begin
            if (int'(s) < nch) begin
                e.out   = d[int'(s)*4 +: 4];
                e.valid = 1'b1;
                e.ch    = s;
            end
        end else if (en && md) begin
            c       = (n / dwell) % nch;
            e.out   = d[c*4 +: 4];
            e.valid = 1'b1;
            e.ch    = c[1:0];
            e.wrap  = (n > 0) && (n % (dwell * nch) == 0);
        end
        return e;
    endfunction

    task automatic cyc(input string tag,
                       input logic e4, input logic m4, input logic [1:0] s4,
                       input logic e3, input logic m3, input logic [1:0] s3);
        exp_t x;
        en4 = e4; md4 = m4; sel4 = s4;
        en3 = e3; md3 = m3; sel3 = s3;
        if (e4 && m4 && !sc4) n4 = 0;
        q4.push_back(predict(e4, m4, s4, din4, 4, 2, n4));
        if (e4 && m4) begin n4++; sc4 = 1'b1; end else sc4 = 1'b0;
        if (e3 && m3 && !sc3) n3 = 0;
        q3.push_back(predict(e3, m3, s3, {4'h0, din3}, 3, 1, n3));
        if (e3 && m3) begin n3++; sc3 = 1'b1; end else sc3 = 1'b0;
        @(posedge clk);
        #1;
        if (q4.size() == 0) check({tag, "/q4_empty"}, 32'd1, 32'd0);
        else begin
            x = q4.pop_front();
            check({tag, "/nch4"}, {o4, v4, ch4, w4}, x);
        end
        if (q3.size() == 0) check({tag, "/q3_empty"}, 32'd1, 32'd0);
        else begin
            x = q3.pop_front();
            check({tag, "/nch3"}, {o3, v3, ch3, w3}, x);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        din4  = 16'h8421;
        din3  = 12'h421;
        en4 = 1'b0; md4 = 1'b0; sel4 = '0;
        en3 = 1'b0; md3 = 1'b0; sel3 = '0;
        #12;
        check("reset4", {o4, v4, ch4, w4}, 32'd0);
        check("reset3", {o3, v3, ch3, w3}, 32'd0);
        rst_n = 1'b1;

        // manual select, then disable and re-enable
        cyc("man_sel2", 1, 0, 2'd2, 0, 0, 2'd0);
        cyc("man_sel3", 1, 0, 2'd3, 0, 0, 2'd0);
        cyc("disable",  0, 0, 2'd3, 0, 0, 2'd0);
        cyc("reenable", 1, 0, 2'd3, 0, 0, 2'd0);

        // ten scan edges: two per channel, wrap on the ninth
        for (int i = 0; i < 10; i++) cyc($sformatf("scan%0d", i), 1, 1, 2'd3, 0, 0, 2'd0);
        cyc("scan_idle", 0, 1, 2'd0, 0, 0, 2'd0);

        // scan, drop to manual, re-enter scan from channel 0
        for (int i = 0; i < 3; i++) cyc($sformatf("pre%0d", i), 1, 1, 2'd0, 0, 0, 2'd0);
        cyc("mid_manual", 1, 0, 2'd1, 0, 0, 2'd0);
        for (int i = 0; i < 5; i++) cyc($sformatf("restart%0d", i), 1, 1, 2'd1, 0, 0, 2'd0);

        // din changes mid-dwell show up on the next edge
        din4 = 16'h3C5A;
        cyc("din_change", 1, 1, 2'd0, 0, 0, 2'd0);
        din4 = 16'h8421;

        // asynchronous reset between edges while scanning
        #2 rst_n = 1'b0;
        #1;
        check("async_rst4", {o4, v4, ch4, w4}, 32'd0);
        check("async_rst3", {o3, v3, ch3, w3}, 32'd0);
        sc4 = 1'b0;
        sc3 = 1'b0;
        #10 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("post_rst%0d", i), 1, 1, 2'd0, 0, 0, 2'd0);

        // three-channel instance: out-of-range select, then DWELL=1 scan
        cyc("n3_sel3", 0, 0, 2'd0, 1, 0, 2'd3);
        cyc("n3_sel2", 0, 0, 2'd0, 1, 0, 2'd2);
        for (int i = 0; i < 5; i++) cyc($sformatf("n3_scan%0d", i), 0, 0, 2'd0, 1, 1, 2'd3);
        cyc("n3_sel0", 0, 0, 2'd0, 1, 0, 2'd0);

        // random mix on both instances
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                din4 = 16'($urandom);
                din3 = 12'($urandom);
            end
            cyc($sformatf("rnd%0d", i),
                ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
